// File: rtl/axi_register_file_v2.sv
// AXI4-Lite slave register file with per-register RW / RO / W1C modes and a user-logic side port.
// Optional macro AXI_REGFILE_ERR_EN enables DECERR/SLVERR responses; without it every response is OKAY.
module axi_register_file_v2 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    REG_COUNT  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASEADDR   = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [REG_COUNT-1:0]  RO_MASK    = '0,
  parameter logic [REG_COUNT-1:0]  W1C_MASK   = '0
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [ADDR_WIDTH-1:0]           AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [DATA_WIDTH-1:0]           WDATA,
  input  logic [DATA_WIDTH/8-1:0]         WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [ADDR_WIDTH-1:0]           ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [DATA_WIDTH-1:0]           RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] REG_IN,
  input  logic [REG_COUNT-1:0]            REG_IN_VALID,
  output logic [REG_COUNT*DATA_WIDTH-1:0] REG_OUT,
  output logic [REG_COUNT-1:0]            REG_OUT_VALID
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [IDX_W:0] REG_CNT = (IDX_W+1)'(REG_COUNT);

  // Hit when the bits above the index match the window base and the index names a real register.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] tag_diff;
    logic [IDX_W:0]        idx;
    tag_diff = (a ^ BASEADDR) >> (ADDR_LSB + IDX_W);
    idx      = {1'b0, a[ADDR_LSB +: IDX_W]};
    return (tag_diff == '0) && (idx < REG_CNT);
  endfunction

  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  commit;
  logic                  wr_hit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_bmask;
  logic [REG_COUNT-1:0]  commit_sel;
  logic                  rd_hit;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] reg_arr [REG_COUNT];

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    commit = aw_full_q && w_full_q && !bvalid_q;
    wr_hit = addr_hit(aw_addr_q);
    wr_idx = aw_addr_q[ADDR_LSB +: IDX_W];
    for (int b = 0; b < STRB_W; b++) begin
      wr_bmask[b*8 +: 8] = {8{w_strb_q[b]}};
    end
    for (int r = 0; r < REG_COUNT; r++) begin
      commit_sel[r] = commit && wr_hit && (wr_idx == IDX_W'(r));
    end

    if (AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
`ifdef AXI_REGFILE_ERR_EN
      if (!wr_hit)                bresp_d = 2'b11;
      else if (RO_MASK[wr_idx])   bresp_d = 2'b10;
      else                        bresp_d = 2'b00;
`else
      bresp_d = 2'b00;
`endif
    end
    // Slots stay closed while a response is outstanding so only one write is ever in flight.
    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_hit   = addr_hit(ARADDR);
    rd_idx   = ARADDR[ADDR_LSB +: IDX_W];
    if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ARVALID && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? reg_arr[rd_idx] : '0;
`ifdef AXI_REGFILE_ERR_EN
      rresp_d  = rd_hit ? 2'b00 : 2'b11;
`else
      rresp_d  = 2'b00;
`endif
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      localparam bit IS_RO  = RO_MASK[gi];
      localparam bit IS_W1C = W1C_MASK[gi] && !RO_MASK[gi];

      logic [DATA_WIDTH-1:0] reg_q, reg_d;
      logic [DATA_WIDTH-1:0] reg_in;
      logic                  out_vld_q, out_vld_d;

      assign reg_in = REG_IN[gi*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        reg_d     = reg_q;
        out_vld_d = commit_sel[gi] && !IS_RO;
        if (IS_RO) begin
          if (REG_IN_VALID[gi]) reg_d = reg_in;
        end else if (IS_W1C) begin
          // Sets from user logic are OR-ed in after the clear so no event is lost.
          reg_d = (reg_q & ~(commit_sel[gi] ? (w_data_q & wr_bmask) : '0))
                | (REG_IN_VALID[gi] ? reg_in : '0);
        end else begin
          if (commit_sel[gi])        reg_d = (reg_q & ~wr_bmask) | (w_data_q & wr_bmask);
          else if (REG_IN_VALID[gi]) reg_d = reg_in;
        end
      end

      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          reg_q     <= '0;
          out_vld_q <= 1'b0;
        end else begin
          reg_q     <= reg_d;
          out_vld_q <= out_vld_d;
        end
      end

      assign reg_arr[gi]                             = reg_q;
      assign REG_OUT[gi*DATA_WIDTH +: DATA_WIDTH]    = reg_q;
      assign REG_OUT_VALID[gi]                       = out_vld_q;
    end
  endgenerate

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_register_file_v2.sv
// Directed testbench for axi_register_file_v2: 6 registers, reg 1 read-only, reg 3 write-1-to-clear.
module tb_axi_register_file_v2;

  localparam int NREG = 6;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AXI_REGFILE_ERR_EN
  localparam logic [1:0] EXP_RO_RESP  = 2'b10;
  localparam logic [1:0] EXP_OOR_RESP = 2'b11;
`else
  localparam logic [1:0] EXP_RO_RESP  = 2'b00;
  localparam logic [1:0] EXP_OOR_RESP = 2'b00;
`endif

  logic               CLK = 1'b0;
  logic               RESETN;
  logic [31:0]        AWADDR;
  logic               AWVALID;
  logic               AWREADY;
  logic [31:0]        WDATA;
  logic [3:0]         WSTRB;
  logic               WVALID;
  logic               WREADY;
  logic [1:0]         BRESP;
  logic               BVALID;
  logic               BREADY;
  logic [31:0]        ARADDR;
  logic               ARVALID;
  logic               ARREADY;
  logic [31:0]        RDATA;
  logic [1:0]         RRESP;
  logic               RVALID;
  logic               RREADY;
  logic [NREG*32-1:0] REG_IN;
  logic [NREG-1:0]    REG_IN_VALID;
  logic [NREG*32-1:0] REG_OUT;
  logic [NREG-1:0]    REG_OUT_VALID;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_regs [NREG];

  axi_register_file_v2 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_COUNT(NREG), .BASEADDR(BASE),
    .RO_MASK(6'b000010), .W1C_MASK(6'b001000)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REG_IN(REG_IN), .REG_IN_VALID(REG_IN_VALID),
    .REG_OUT(REG_OUT), .REG_OUT_VALID(REG_OUT_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [NREG*32-1:0] exp_flat();
    logic [NREG*32-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  // Drive AW and W together, then collect the response; called #1 after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs;
    int cyc = 0;
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1;
    resp = 2'bxx;
    while (AWVALID || WVALID) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge CLK); #1;
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID  = 1'b0;
      if (++cyc > 50) begin
        n_cmp++; n_mis++;
        $display("FAIL write_handshake_timeout addr=%h got no ready, required ready", addr);
        AWVALID = 1'b0; WVALID = 1'b0;
        return;
      end
    end
    cyc = 0;
    while (!BVALID) begin
      @(posedge CLK); #1;
      if (++cyc > 50) begin
        n_cmp++; n_mis++;
        $display("FAIL bvalid_timeout addr=%h got BVALID=0, required 1", addr);
        return;
      end
    end
    resp = BRESP;
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    $display("WR addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    logic ar_hs;
    int cyc = 0;
    ARADDR = addr; ARVALID = 1'b1;
    data = 'x; resp = 'x; lat = -1;
    while (ARVALID) begin
      ar_hs = ARREADY;
      @(posedge CLK); #1;
      if (ar_hs) ARVALID = 1'b0;
      if (++cyc > 50) begin
        n_cmp++; n_mis++;
        $display("FAIL arready_timeout addr=%h got ARREADY=0, required 1", addr);
        ARVALID = 1'b0;
        return;
      end
    end
    lat = 0;
    while (!RVALID) begin
      @(posedge CLK); #1;
      if (++lat > 50) begin
        n_cmp++; n_mis++;
        $display("FAIL rvalid_timeout addr=%h got RVALID=0, required 1", addr);
        return;
      end
    end
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(posedge CLK); #1;
    RREADY = 1'b0;
    $display("RD addr=%h rdata=%h rresp=%0d lat=%0d", addr, data, resp, lat);
  endtask

  task automatic test_reset();
    RESETN = 1'b1;
    #2 RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_mis++;
      $display("FAIL reset_ready got %b required 000", {AWREADY, WREADY, ARREADY}); end
    n_cmp++; if ({BVALID, RVALID} !== 2'b00) begin n_mis++;
      $display("FAIL reset_valid got %b required 00", {BVALID, RVALID}); end
    n_cmp++; if ({BRESP, RRESP, RDATA} !== 36'h0) begin n_mis++;
      $display("FAIL reset_resp_data got %h required 0", {BRESP, RRESP, RDATA}); end
    n_cmp++; if (REG_OUT !== '0 || REG_OUT_VALID !== '0) begin n_mis++;
      $display("FAIL reset_regs got %h/%b required 0", REG_OUT, REG_OUT_VALID); end
    RESETN = 1'b1;
    #1;
    n_cmp++; if (AWREADY !== 1'b0) begin n_mis++;
      $display("FAIL ready_before_edge got %b required 0", AWREADY); end
    @(posedge CLK); #1;
    n_cmp++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_mis++;
      $display("FAIL ready_after_release got %b required 111", {AWREADY, WREADY, ARREADY}); end
  endtask

  task automatic test_rw_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    AWADDR = BASE + 32'h8; WDATA = 32'hDEAD_BEEF; WSTRB = 4'b0101;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge CLK); #1;                       // handshake edge (cycle N)
    AWVALID = 1'b0; WVALID = 1'b0;
    n_cmp++; if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin n_mis++;
      $display("FAIL strobe_n1 got BVALID=%b AWREADY=%b required 0/0", BVALID, AWREADY); end
    @(posedge CLK); #1;                       // commit edge, now in N+2
    n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_mis++;
      $display("FAIL strobe_bresp got BVALID=%b BRESP=%b required 1/00", BVALID, BRESP); end
    n_cmp++; if (REG_OUT[2*32 +: 32] !== 32'h00AD_00EF) begin n_mis++;
      $display("FAIL strobe_reg2 got %h required 00ad00ef", REG_OUT[2*32 +: 32]); end
    n_cmp++; if (REG_OUT_VALID !== 6'b000100) begin n_mis++;
      $display("FAIL strobe_out_valid got %b required 000100", REG_OUT_VALID); end
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    n_cmp++; if (REG_OUT_VALID !== 6'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_mis++;
      $display("FAIL strobe_after_b got vld=%b BVALID=%b AWREADY=%b required 0/0/1",
               REG_OUT_VALID, BVALID, AWREADY); end
    $display("WR addr=%h data=deadbeef strb=5 bresp=0", BASE + 32'h8);
    exp_regs[2] = 32'h00AD_00EF;
    do_read(BASE + 32'h8, d, r, lat);
    n_cmp++; if (d !== 32'h00AD_00EF || r !== 2'b00 || lat !== 0) begin n_mis++;
      $display("FAIL strobe_readback got %h/%b lat %0d required 00ad00ef/00 lat 0", d, r, lat); end
  endtask

  task automatic test_w_before_aw();
    int b_count = 0;
    WDATA = 32'h0000_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge CLK); #1;
    WVALID = 1'b0;
    n_cmp++; if (WREADY !== 1'b0) begin n_mis++;
      $display("FAIL w_first_wready got %b required 0", WREADY); end
    repeat (2) begin
      @(posedge CLK); #1;
      if (BVALID) b_count++;
    end
    AWADDR = BASE + 32'h10; AWVALID = 1'b1;
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    if (BVALID) b_count++;
    @(posedge CLK); #1;                        // commit edge
    n_cmp++; if (BVALID !== 1'b1 || REG_OUT[4*32 +: 32] !== 32'h0000_A5A5) begin n_mis++;
      $display("FAIL w_first_commit got BVALID=%b reg4=%h required 1/0000a5a5",
               BVALID, REG_OUT[4*32 +: 32]); end
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (BVALID !== 1'b1) begin n_mis++;
      $display("FAIL w_first_bhold got %b required 1", BVALID); end
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    b_count++;
    repeat (3) begin
      @(posedge CLK); #1;
      if (BVALID) b_count++;
    end
    n_cmp++; if (b_count !== 1) begin n_mis++;
      $display("FAIL w_first_bcount got %0d required 1", b_count); end
    $display("WR addr=%h data=0000a5a5 strb=f (W before AW)", BASE + 32'h10);
    exp_regs[4] = 32'h0000_A5A5;
  endtask

  task automatic test_rw_regin();
    REG_IN[0 +: 32] = 32'h0000_0055; REG_IN_VALID = 6'b000001;
    @(posedge CLK); #1;
    REG_IN_VALID = '0;
    n_cmp++; if (REG_OUT[0 +: 32] !== 32'h0000_0055) begin n_mis++;
      $display("FAIL rw_regin_load got %h required 00000055", REG_OUT[0 +: 32]); end
    AWADDR = BASE; WDATA = 32'hAAAA_0000; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    REG_IN[0 +: 32] = 32'h0000_1234; REG_IN_VALID = 6'b000001;   // same cycle as commit
    @(posedge CLK); #1;
    REG_IN_VALID = '0;
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    n_cmp++; if (REG_OUT[0 +: 32] !== 32'hAAAA_0000) begin n_mis++;
      $display("FAIL rw_commit_wins got %h required aaaa0000", REG_OUT[0 +: 32]); end
    $display("WR addr=%h data=aaaa0000 strb=f with REG_IN collision", BASE);
    exp_regs[0] = 32'hAAAA_0000;
  endtask

  task automatic test_w1c();
    logic [1:0] r;
    REG_IN[3*32 +: 32] = 32'h0000_000F; REG_IN_VALID = 6'b001000;
    @(posedge CLK); #1;
    REG_IN_VALID = '0;
    n_cmp++; if (REG_OUT[3*32 +: 32] !== 32'h0000_000F) begin n_mis++;
      $display("FAIL w1c_preload got %h required 0000000f", REG_OUT[3*32 +: 32]); end
    AWADDR = BASE + 32'hC; WDATA = 32'h0000_0003; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    REG_IN[3*32 +: 32] = 32'h0000_0010; REG_IN_VALID = 6'b001000;
    @(posedge CLK); #1;
    REG_IN_VALID = '0;
    n_cmp++; if (REG_OUT[3*32 +: 32] !== 32'h0000_001C || REG_OUT_VALID !== 6'b001000) begin n_mis++;
      $display("FAIL w1c_set_and_clear got %h/%b required 0000001c/001000",
               REG_OUT[3*32 +: 32], REG_OUT_VALID); end
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    $display("WR addr=%h data=00000003 strb=f with REG_IN set", BASE + 32'hC);
    do_write(BASE + 32'hC, 32'h0000_0010, 4'hF, r);
    n_cmp++; if (REG_OUT[3*32 +: 32] !== 32'h0000_000C || r !== 2'b00) begin n_mis++;
      $display("FAIL w1c_clear got %h/%b required 0000000c/00", REG_OUT[3*32 +: 32], r); end
    exp_regs[3] = 32'h0000_000C;
  endtask

  task automatic test_ro();
    logic [1:0] r;
    REG_IN[1*32 +: 32] = 32'h1234_5678; REG_IN_VALID = 6'b000010;
    @(posedge CLK); #1;
    REG_IN_VALID = '0;
    exp_regs[1] = 32'h1234_5678;
    do_write(BASE + 32'h4, 32'h0, 4'hF, r);
    n_cmp++; if (REG_OUT[1*32 +: 32] !== 32'h1234_5678) begin n_mis++;
      $display("FAIL ro_unchanged got %h required 12345678", REG_OUT[1*32 +: 32]); end
    n_cmp++; if (r !== EXP_RO_RESP) begin n_mis++;
      $display("FAIL ro_bresp got %b required %b", r, EXP_RO_RESP); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(BASE + 32'h18, d, r, lat);
    n_cmp++; if (d !== 32'h0 || r !== EXP_OOR_RESP) begin n_mis++;
      $display("FAIL oor_read_index got %h/%b required 0/%b", d, r, EXP_OOR_RESP); end
    do_read(BASE + 32'h0010_0000, d, r, lat);
    n_cmp++; if (d !== 32'h0 || r !== EXP_OOR_RESP) begin n_mis++;
      $display("FAIL oor_read_tag got %h/%b required 0/%b", d, r, EXP_OOR_RESP); end
    do_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, r);
    n_cmp++; if (r !== EXP_OOR_RESP) begin n_mis++;
      $display("FAIL oor_write_resp got %b required %b", r, EXP_OOR_RESP); end
    n_cmp++; if (REG_OUT !== exp_flat()) begin n_mis++;
      $display("FAIL oor_write_regs got %h required %h", REG_OUT, exp_flat()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    ARADDR = BASE + 32'h8; ARVALID = 1'b1;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    n_cmp++; if (RVALID !== 1'b1 || RDATA !== 32'h00AD_00EF) begin n_mis++;
      $display("FAIL mid_read got %b/%h required 1/00ad00ef", RVALID, RDATA); end
    @(posedge CLK); #1;
    n_cmp++; if (RVALID !== 1'b1 || RDATA !== 32'h00AD_00EF) begin n_mis++;
      $display("FAIL mid_read_hold got %b/%h required 1/00ad00ef", RVALID, RDATA); end
    #2 RESETN = 1'b0;
    #1;
    n_cmp++; if (RVALID !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0 || REG_OUT !== '0) begin
      n_mis++;
      $display("FAIL mid_reset_async got RVALID=%b RDATA=%h ARREADY=%b REG_OUT=%h required 0/0/0/0",
               RVALID, RDATA, ARREADY, REG_OUT); end
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    for (int i = 0; i < NREG; i++) begin
      do_read(BASE + 32'(i * 4), d, r, lat);
      n_cmp++; if (d !== 32'h0 || r !== 2'b00) begin n_mis++;
        $display("FAIL post_reset_read reg%0d got %h/%b required 0/00", i, d, r); end
    end
  endtask

  initial begin
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; REG_IN = '0; REG_IN_VALID = '0;
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    test_reset();
    test_rw_strobe();
    test_w_before_aw();
    test_rw_regin();
    test_w1c();
    test_ro();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
